// File: rtl/instr_fetch_if.sv
// Bundle of fetch-unit signals: instruction-memory port, redirect, output stream.
// No logic and no latency of its own; it only carries wires.
// The consumer drives out_ready; the fetch unit holds the head while it is low.
interface instr_fetch_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  // Fetch-unit side.
  modport master (
    output imem_addr, imem_req, out_valid, out_instr, out_pc,
    input  imem_data, redirect, redirect_pc, out_ready
  );

  // Environment side: memory, branch resolution and the consumer.
  modport slave (
    input  imem_addr, imem_req, out_valid, out_instr, out_pc,
    output imem_data, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Sequential instruction fetch into a DEPTH-entry buffer, with redirect flush.
// Latency: an address issued in cycle N reaches the buffer head in cycle N+2.
// Backpressure: issue stalls once buffered + in-flight words would exceed DEPTH.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;

  // Fetch-side state
  logic [31:0]   r_pc;
  logic          r_inflight_v;
  logic [31:0]   r_inflight_pc;

  // Buffer state
  logic [CW-1:0] r_count;
  ptr_t          r_rd_ptr;
  ptr_t          r_wr_ptr;
  logic [31:0]   r_buf_instr [DEPTH];
  logic [31:0]   r_buf_pc    [DEPTH];

  logic          w_out_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [CW:0]   w_occ;
  ptr_t          w_rd_ptr_nxt;
  ptr_t          w_wr_ptr_nxt;

  // Head is valid whenever anything is buffered.
  assign w_out_valid = (r_count != '0);

  // A pop during redirect or reset is void: the flush wins.
  assign w_pop  = w_out_valid & bus.out_ready & ~rst & ~bus.redirect;

  // The word requested last cycle arrives now; redirect discards it.
  assign w_push = r_inflight_v & ~rst & ~bus.redirect;

  // Occupancy after this edge if nothing new is issued. Never underflows,
  // since a pop needs at least one buffered entry.
  assign w_occ   = {1'b0, r_count} + (CW+1)'(r_inflight_v) - (CW+1)'(w_pop);
  assign w_issue = ~rst & ~bus.redirect & (w_occ < (CW+1)'(DEPTH));

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  assign w_rd_ptr_nxt = (r_rd_ptr == ptr_t'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
  assign w_wr_ptr_nxt = (r_wr_ptr == ptr_t'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;

  // Memory port: the address is always the current pc, even in reset.
  assign bus.imem_addr = r_pc;
  assign bus.imem_req  = w_issue;

  // Output head; forced to zero when the buffer is empty.
  assign bus.out_valid = w_out_valid;
  assign bus.out_instr = w_out_valid ? r_buf_instr[r_rd_ptr] : '0;
  assign bus.out_pc    = w_out_valid ? r_buf_pc[r_rd_ptr]    : '0;

  // Fetch pc and in-flight tracking; reset beats redirect beats normal issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight_v  <= 1'b0;
      r_inflight_pc <= '0;
    end else if (bus.redirect) begin
      r_pc          <= bus.redirect_pc;
      r_inflight_v  <= 1'b0;
    end else begin
      r_inflight_v <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + 32'd1;
      end
    end
  end

  // Buffer occupancy and pointers; a flush empties the buffer outright.
  always_ff @(posedge clk) begin
    if (rst || bus.redirect) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
    end
  end

  // Buffer storage; contents beyond count are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_instr[r_wr_ptr] <= bus.imem_data;
      r_buf_pc[r_wr_ptr]    <= r_inflight_pc;
    end
  end

endmodule
